// File: rtl/seq_pkg.sv
// seq_pkg: state encoding and default pattern shared by the 1011 stream generator
package seq_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;
  localparam int PAT_W_DEF = 4;
  localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 4'b1011;
endpackage

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: PAT_W-bit load/shift register with bit index, MSB-first
//  load     in  1  reload PATTERN, first bit appears next cycle
//  shift    in  1  advance to the next pattern bit
//  inv      in  1  invert the bit being shifted into the output position
//  cur_bit  out 1  bit currently on the stream (0 when neither load nor shift)
//  last_bit out 1  current bit is bit 0 of the pattern
//  pre_last out 1  a shift now would present bit 0
module seq_bit_serializer #(
  parameter int PAT_W = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic shift,
  input  logic inv,
  output logic cur_bit,
  output logic last_bit,
  output logic pre_last
);
  localparam int IW = $clog2(PAT_W);
  localparam logic [IW-1:0] TOP_IDX = IW'(PAT_W - 1);
  logic [PAT_W-1:0] sh_q, sh_d;
  logic [IW-1:0] bit_idx_q, bit_idx_d;
  // Register clears whenever idle so cur_bit can drive x directly as a flop.
  always_comb begin
    sh_d = load ? PATTERN : shift ? {sh_q[PAT_W-2:0], 1'b0} ^ {inv, {(PAT_W-1){1'b0}}} : '0;
    bit_idx_d = load ? TOP_IDX : shift ? bit_idx_q - IW'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_q <= '0;
      bit_idx_q <= '0;
    end else begin
      sh_q <= sh_d;
      bit_idx_q <= bit_idx_d;
    end
  assign cur_bit = sh_q[PAT_W-1];
  assign last_bit = bit_idx_q == '0;
  assign pre_last = bit_idx_q == IW'(1);
endmodule

// File: rtl/seq_1011_gen.sv
// seq_1011_gen: serializes PATTERN MSB-first rep_cnt times with gap_len zero bits between
//  clk, rst_n          clock, async active-low reset
//  start, abort        run request (IDLE only) / return to IDLE (highest priority)
//  rep_cnt, gap_len    repeat count and inter-pattern gap, latched on start
//  err_inj             only with SEQ_GEN_ERR_INJECT_EN: invert last bit, drop pat_end
//  x, x_valid          serial bit and its qualifier
//  pat_end, busy, done last-bit strobe, run active, end-of-run pulse
module seq_1011_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_len,
`ifdef SEQ_GEN_ERR_INJECT_EN
  input  logic             err_inj,
`endif
  output logic             x,
  output logic             x_valid,
  output logic             pat_end,
  output logic             busy,
  output logic             done
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] reps_left_q, reps_left_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d, gap_ctr_q, gap_ctr_d;
  logic x_valid_q, x_valid_d, pat_end_q, pat_end_d, busy_q, busy_d, done_q, done_d;
  logic load, shift, inv, cur_bit, last_bit, pre_last;
  seq_bit_serializer #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_ser (
    .clk(clk), .rst_n(rst_n), .load(load), .shift(shift), .inv(inv),
    .cur_bit(cur_bit), .last_bit(last_bit), .pre_last(pre_last)
  );
`ifdef SEQ_GEN_ERR_INJECT_EN
  assign inv = err_inj & shift & pre_last;
`else
  assign inv = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      reps_left_q <= '0;
      gap_len_q <= '0;
      gap_ctr_q <= '0;
      x_valid_q <= 1'b0;
      pat_end_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      reps_left_q <= reps_left_d;
      gap_len_q <= gap_len_d;
      gap_ctr_q <= gap_ctr_d;
      x_valid_q <= x_valid_d;
      pat_end_q <= pat_end_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  // load/shift describe what the serializer presents next cycle, so every
  // output below is computed for the state being entered.
  always_comb begin
    state_d = state_q;
    reps_left_d = reps_left_q;
    gap_len_d = gap_len_q;
    gap_ctr_d = gap_ctr_q;
    load = 1'b0;
    shift = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        reps_left_d = rep_cnt;
        gap_len_d = gap_len;
        load = rep_cnt != '0;
        state_d = load ? SEND : DONE;
      end
      SEND: if (last_bit) begin
        reps_left_d = reps_left_q - CNT_W'(1);
        gap_ctr_d = gap_len_q;
        load = reps_left_q != CNT_W'(1) && gap_len_q == '0;
        state_d = reps_left_q == CNT_W'(1) ? DONE : gap_len_q != '0 ? GAP : SEND;
      end else shift = 1'b1;
      GAP: begin
        load = gap_ctr_q == GAP_W'(1);
        gap_ctr_d = gap_ctr_q - GAP_W'(1);
        state_d = load ? SEND : GAP;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      load = 1'b0;
      shift = 1'b0;
    end
  end
  always_comb begin
    x_valid_d = state_d == SEND || state_d == GAP;
    pat_end_d = shift && pre_last && !inv;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  assign x = cur_bit;
  assign x_valid = x_valid_q;
  assign pat_end = pat_end_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
